// File: rtl/mem_responder.sv
// Unified instruction/data memory responder: a 1-cycle instruction fetch port and a
// wait-stated data port (IDLE/BUSY/DONE). Optional macro MEM_RO_TEXT_EN makes words below TEXT_LIMIT read-only.
module mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int LAT        = 2,
  parameter int TEXT_LIMIT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_o,
  input  logic              ldst_req_i,
  input  logic              ldst_write_i,
  input  logic [ADDR_W-1:0] ldst_addr_i,
  input  logic [DATA_W-1:0] ldst_data_i,
  output logic [DATA_W-1:0] ldst_data_o,
  output logic              ack_o,
  output logic              stall_o,
  output logic              err_o,
  input  logic              hlt_i
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] inst_q;
  logic              ack_q, stall_q, err_q, err_d;

  logic inst_ok, addr_ok, ro_hit, access, wr_en;

  assign inst_ok = inst_addr_i < ADDR_W'(DEPTH);
  assign addr_ok = addr_q < ADDR_W'(DEPTH);
`ifdef MEM_RO_TEXT_EN
  assign ro_hit  = wr_q && (addr_q < ADDR_W'(TEXT_LIMIT));
`else
  assign ro_hit  = 1'b0;
`endif
  assign access  = (state_q == S_BUSY) && (cnt_q == 4'd0);
  assign wr_en   = access && wr_q && addr_ok && !ro_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ldst_req_i && !hlt_i) begin
          addr_d  = ldst_addr_i;
          data_d  = ldst_data_i;
          wr_d    = ldst_write_i;
          cnt_d   = 4'(LAT);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          err_d   = !addr_ok || ro_hit;
          if (!wr_q) rdata_d = addr_ok ? mem[addr_q[IDX_W-1:0]] : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so stall_o has no input-to-output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ack_q   <= (state_d == S_DONE);
      stall_q <= (state_d == S_BUSY);
      err_q   <= err_d;
    end
  end

  // Array is never reset; a reset mid-access leaves state IDLE so no write edge occurs.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q[IDX_W-1:0]] <= data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) inst_q <= '0;
    else        inst_q <= inst_ok ? mem[inst_addr_i[IDX_W-1:0]] : '0;
  end

  assign inst_o      = inst_q;
  assign ldst_data_o = rdata_q;
  assign ack_o       = ack_q;
  assign stall_o     = stall_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, corner sequences,
// and randomized accesses checked against an associative-array memory model.
module tb_mem_responder;

  localparam int DEPTH      = 1024;
  localparam int TEXT_LIMIT = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req [2];
  logic        wr  [2];
  logic        hlt [2];
  logic [31:0] iaddr [2];
  logic [31:0] laddr [2];
  logic [31:0] wdata [2];
  logic [31:0] inst  [2];
  logic [31:0] rdat  [2];
  logic        ack   [2];
  logic        stall [2];
  logic        err   [2];

  mem_responder #(.LAT(2)) dut0 (
    .clk(clk), .reset(reset), .inst_addr_i(iaddr[0]), .inst_o(inst[0]),
    .ldst_req_i(req[0]), .ldst_write_i(wr[0]), .ldst_addr_i(laddr[0]),
    .ldst_data_i(wdata[0]), .ldst_data_o(rdat[0]), .ack_o(ack[0]),
    .stall_o(stall[0]), .err_o(err[0]), .hlt_i(hlt[0]));

  mem_responder #(.LAT(0)) dut1 (
    .clk(clk), .reset(reset), .inst_addr_i(iaddr[1]), .inst_o(inst[1]),
    .ldst_req_i(req[1]), .ldst_write_i(wr[1]), .ldst_addr_i(laddr[1]),
    .ldst_data_i(wdata[1]), .ldst_data_o(rdat[1]), .ack_o(ack[1]),
    .stall_o(stall[1]), .err_o(err[1]), .hlt_i(hlt[1]));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] known [int];
  logic [31:0] last_rd = 32'h0;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;
  vec_t tbl [7];

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic bit ro_blk(input int a);
`ifdef MEM_RO_TEXT_EN
    return a < TEXT_LIMIT;
`else
    return a < 0;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One data access; inputs change on the falling edge, outputs sampled on the falling edge.
  task automatic access(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, input bit hb, output int ns, output logic ga, output logic ge,
                        output logic [31:0] rd, output logic [31:0] ia, output logic [31:0] inx);
    ns = 0; ga = 1'b0; ge = 1'b0; rd = '0; ia = '0;
    @(negedge clk);
    req[u] = 1'b1; wr[u] = w; laddr[u] = a; wdata[u] = d;
    @(posedge clk); #1;
    if (!hold) req[u] = 1'b0;
    if (hb) hlt[u] = 1'b1;
    for (int i = 0; i < 40 && !ga; i++) begin
      @(negedge clk);
      if (stall[u]) ns++;
      if (ack[u]) begin
        ga = 1'b1; ge = err[u]; rd = rdat[u]; ia = inst[u];
      end else if (err[u]) begin
        check("err without ack", 32'(err[u]), 32'h0);
      end
    end
    @(negedge clk);
    inx = inst[u];
    check("ack one cycle", 32'(ack[u]), 32'h0);
    check("no accept in done", 32'(stall[u]), 32'h0);
    req[u] = 1'b0; hlt[u] = 1'b0;
  endtask

  task automatic run(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_rd, input string nm);
    int ns; logic ga, ge; logic [31:0] rd, ia, inx;
    access(u, w, a, d, 1'b0, 1'b0, ns, ga, ge, rd, ia, inx);
    check({nm, " stall"}, 32'(ns), 32'(lat_of(u) + 1));
    check({nm, " ack"}, 32'(ga), 32'h1);
    check({nm, " err"}, 32'(ge), 32'(e_err));
    check({nm, " data"}, rd, e_rd);
  endtask

  initial begin
    int ns, na, pool [8];
    logic ga, ge;
    logic [31:0] rd, ia, inx, v, e;

    pool = '{3, 7, 300, 301, 555, 1023, 1024, 5000};
    tbl[0] = '{1'b1, 32'd300,       32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'd300,       32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 32'(DEPTH + 3), 32'h0,       1'b1, 32'h0};
    tbl[3] = '{1'b1, 32'd976,       32'h00976976, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 32'd2000,      32'h0BAD0BAD, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 32'd976,       32'h0,        1'b0, 32'h00976976};
    tbl[6] = '{1'b1, 32'd400,       32'h0BADF00D, 1'b0, 32'h00976976};

    for (int u = 0; u < 2; u++) begin
      req[u] = 0; wr[u] = 0; hlt[u] = 0; iaddr[u] = 0; laddr[u] = 0; wdata[u] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst inst", inst[u], 32'h0);
      check("rst rdata", rdat[u], 32'h0);
      check("rst ack", 32'(ack[u]), 32'h0);
      check("rst stall", 32'(stall[u]), 32'h0);
      check("rst err", 32'(err[u]), 32'h0);
    end
    reset = 1'b1;

    for (int i = 0; i < 7; i++)
      run(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e_err, tbl[i].e_rd, $sformatf("vec%0d", i));
    known[300] = 32'hDEADBEEF; known[976] = 32'h00976976; known[400] = 32'h0BADF00D;
    last_rd = 32'h00976976;

    // Read-before-write on the fetch port
    iaddr[0] = 32'd400;
    access(0, 1'b1, 32'd400, 32'hA5A5A5A5, 1'b0, 1'b0, ns, ga, ge, rd, ia, inx);
    check("rbw ack", 32'(ga), 32'h1);
    check("rbw old", ia, 32'h0BADF00D);
    check("rbw new", inx, 32'hA5A5A5A5);
    known[400] = 32'hA5A5A5A5;

    // Halt blocks acceptance in IDLE
    @(negedge clk);
    hlt[0] = 1'b1; req[0] = 1'b1; wr[0] = 1'b0; laddr[0] = 32'd300;
    ns = 0; na = 0;
    repeat (5) begin
      @(negedge clk);
      ns += int'(stall[0]); na += int'(ack[0]);
    end
    check("hlt stall", 32'(ns), 32'h0);
    check("hlt ack", 32'(na), 32'h0);
    req[0] = 1'b0; hlt[0] = 1'b0;

    // Reset in the second BUSY cycle of a store
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; laddr[0] = 32'd300; wdata[0] = 32'h11111111; iaddr[0] = 32'd300;
    @(posedge clk); #1 req[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst stall", 32'(stall[0]), 32'h0);
    check("arst ack", 32'(ack[0]), 32'h0);
    check("arst err", 32'(err[0]), 32'h0);
    check("arst inst", inst[0], 32'h0);
    check("arst rdata", rdat[0], 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    na = 0;
    repeat (6) begin
      @(negedge clk);
      na += int'(ack[0]);
    end
    check("arst no ack", 32'(na), 32'h0);
    check("arst fetch 300", inst[0], 32'hDEADBEEF);
    last_rd = 32'h0;
    run(0, 1'b0, 32'd300, 32'h0, 1'b0, 32'hDEADBEEF, "ld300 after rst");
    last_rd = 32'hDEADBEEF;

    // Zero-wait-state instance
    run(1, 1'b1, 32'd5, 32'h12345678, 1'b0, 32'h0, "lat0 st5");
    run(1, 1'b0, 32'd5, 32'h0, 1'b0, 32'h12345678, "lat0 ld5");

    // Low word: read-only only when the text-protect option is built in
    access(0, 1'b0, 32'd10, 32'h0, 1'b0, 1'b0, ns, ga, ge, v, ia, inx);
    check("ld10 ack", 32'(ga), 32'h1);
    run(0, 1'b1, 32'd10, 32'h00001010, ro_blk(10), v, "st10");
    e = ro_blk(10) ? v : 32'h00001010;
    run(0, 1'b0, 32'd10, 32'h0, 1'b0, e, "ld10");
    known[10] = e; last_rd = e;

    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      run(0, 1'b1, 32'(pool[i]), v, ro_blk(pool[i]), last_rd, "init");
      if (!ro_blk(pool[i])) known[pool[i]] = v;
    end

    // Randomized accesses against the model
    for (int n = 0; n < 60; n++) begin
      int a, fa;
      logic w, oob, e_err;
      bit hold, hb;
      a = pool[$urandom % 8];
      fa = pool[$urandom % 8];
      w = 1'($urandom % 2);
      v = $urandom;
      hold = 1'($urandom % 2);
      hb = ($urandom % 4) == 0;
      iaddr[0] = 32'(fa);
      oob = a >= DEPTH;
      e_err = oob || (w && ro_blk(a));
      access(0, w, 32'(a), v, hold, hb, ns, ga, ge, rd, ia, inx);
      check("rnd stall", 32'(ns), 32'(lat_of(0) + 1));
      check("rnd ack", 32'(ga), 32'h1);
      check("rnd err", 32'(ge), 32'(e_err));
      if (w) begin
        check("rnd st data hold", rd, last_rd);
        if (!e_err) known[a] = v;
      end else if (oob) begin
        check("rnd ld oob", rd, 32'h0);
        last_rd = 32'h0;
      end else if (known.exists(a)) begin
        check("rnd ld data", rd, known[a]);
        last_rd = known[a];
      end else begin
        last_rd = rd;
      end
      if (fa >= DEPTH) check("rnd fetch oob", inx, 32'h0);
      else if (known.exists(fa)) check("rnd fetch", inx, known[fa]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
